// File: rtl/alu_sequencer_pkg.sv
// Shared CPU definitions: opcode/func/ALU constants, sequencer state encoding
// and the decoded-control bundle passed from insn_decoder to the sequencer.
package cpu_pkg;

    localparam int WORD_SIZE = 16;

    localparam logic [3:0] OPC_RTYPE = 4'd15;
    localparam logic [3:0] OPC_ADI   = 4'd4;
    localparam logic [3:0] OPC_LHI   = 4'd6;
    localparam logic [3:0] OPC_JMP   = 4'd9;

    localparam logic [5:0] FUNC_ADD = 6'd0;
    localparam logic [5:0] FUNC_WWD = 6'd28;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_LHI = 4'b0001;
    localparam logic [3:0] ALU_WWD = 4'b0010;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0]           alu_op;
        logic                 alu_b_imm;
        logic [WORD_SIZE-1:0] imm;
        logic [1:0]           ra;
        logic [1:0]           rb;
        logic [1:0]           wa;
        logic                 we;
        logic                 wwd;
        logic                 illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        alu_op:    ALU_ADD,
        alu_b_imm: 1'b0,
        imm:       16'h0000,
        ra:        2'd0,
        rb:        2'd0,
        wa:        2'd0,
        we:        1'b0,
        wwd:       1'b0,
        illegal:   1'b0
    };

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction-memory read handshake between the sequencer (master) and memory (slave).
interface alu_sequencer_if;
    import cpu_pkg::*;

    logic                 readM;
    logic [WORD_SIZE-1:0] address;
    logic [WORD_SIZE-1:0] data;
    logic                 inputReady;

    modport master (output readM, output address, input data, input inputReady);
    modport slave  (input readM, input address, output data, output inputReady);

endinterface

// File: rtl/alu_sequencer_decoder.sv
// insn_decoder: purely combinational mapping from an instruction word to the
// datapath selects and execute-cycle strobes.
module insn_decoder
    import cpu_pkg::*;
(
    input  logic [WORD_SIZE-1:0] insn_i,
    output ctrl_t                ctrl_o
);

    // Decode opcode/func into control fields; JMP needs no datapath action here.
    always_comb begin
        ctrl_o    = CTRL_RESET;
        ctrl_o.ra = insn_i[11:10];
        ctrl_o.rb = insn_i[9:8];
        case (insn_i[15:12])
            OPC_RTYPE: begin
                case (insn_i[5:0])
                    FUNC_ADD: begin
                        ctrl_o.alu_op = ALU_ADD;
                        ctrl_o.wa     = insn_i[7:6];
                        ctrl_o.we     = 1'b1;
                    end
                    FUNC_WWD: begin
                        ctrl_o.alu_op = ALU_WWD;
                        ctrl_o.wwd    = 1'b1;
                    end
                    default: ctrl_o.illegal = 1'b1;
                endcase
            end
            OPC_ADI: begin
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.alu_b_imm = 1'b1;
                ctrl_o.imm       = {{8{insn_i[7]}}, insn_i[7:0]};
                ctrl_o.wa        = insn_i[9:8];
                ctrl_o.we        = 1'b1;
            end
            OPC_LHI: begin
                ctrl_o.alu_op    = ALU_LHI;
                ctrl_o.alu_b_imm = 1'b1;
                ctrl_o.imm       = {8'h00, insn_i[7:0]};
                ctrl_o.wa        = insn_i[9:8];
                ctrl_o.we        = 1'b1;
            end
            OPC_JMP: ctrl_o.illegal = 1'b0;
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: FETCH/DECODE/EXEC control unit owning PC and IR.
// Define ALU_SEQ_NUM_INST_EN to add the retired-instruction counter and num_inst port.
module alu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] RESET_PC = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_sequencer_if.master      mem,
    output logic [3:0]           alu_op,
    output logic                 alu_cin,
    output logic                 alu_b_imm,
    output logic [WORD_SIZE-1:0] imm,
    output logic [1:0]           rf_ra,
    output logic [1:0]           rf_rb,
    output logic [1:0]           rf_wa,
    output logic                 rf_we,
    output logic                 wwd_en,
    output logic                 illegal,
    output logic [WORD_SIZE-1:0] pc
`ifdef ALU_SEQ_NUM_INST_EN
    ,
    output logic [WORD_SIZE-1:0] num_inst
`endif
);

    state_e               state_q;
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] ir_q;
    ctrl_t                ctrl_q;
    ctrl_t                dec_s;
    logic                 we_q;
    logic                 wwd_q;
    logic                 ill_q;
`ifdef ALU_SEQ_NUM_INST_EN
    logic [WORD_SIZE-1:0] num_inst_q;
`endif

    // Decoding the fetch bus lets the selects be registered on entry to DECODE.
    insn_decoder u_dec (
        .insn_i (mem.data),
        .ctrl_o (dec_s)
    );

    // Sequencer FSM with its registered datapath selects, strobes and PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= 16'h0000;
            ctrl_q     <= CTRL_RESET;
            we_q       <= 1'b0;
            wwd_q      <= 1'b0;
            ill_q      <= 1'b0;
`ifdef ALU_SEQ_NUM_INST_EN
            num_inst_q <= 16'h0000;
`endif
        end else begin
            we_q  <= 1'b0;
            wwd_q <= 1'b0;
            ill_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (mem.inputReady) begin
                        ir_q    <= mem.data;
                        ctrl_q  <= dec_s;
                        state_q <= DECODE;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                DECODE: begin
                    we_q    <= ctrl_q.we;
                    wwd_q   <= ctrl_q.wwd;
                    ill_q   <= ctrl_q.illegal;
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (ir_q[15:12] == OPC_JMP) begin
                        pc_q <= {pc_q[15:12], ir_q[11:0]};
                    end else begin
                        pc_q <= pc_q + 16'd1;
                    end
`ifdef ALU_SEQ_NUM_INST_EN
                    if (!ill_q) begin
                        num_inst_q <= num_inst_q + 16'd1;
                    end else begin
                        num_inst_q <= num_inst_q;
                    end
`endif
                    state_q <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    // Reset masks the fetch request and strobes in the very cycle it is asserted.
    assign mem.readM   = (state_q == FETCH) && !reset;
    assign mem.address = pc_q;
    assign pc          = pc_q;
    assign alu_op      = ctrl_q.alu_op;
    assign alu_cin     = 1'b0;
    assign alu_b_imm   = ctrl_q.alu_b_imm;
    assign imm         = ctrl_q.imm;
    assign rf_ra       = ctrl_q.ra;
    assign rf_rb       = ctrl_q.rb;
    assign rf_wa       = ctrl_q.wa;
    assign rf_we       = we_q && !reset;
    assign wwd_en      = wwd_q && !reset;
    assign illegal     = ill_q && !reset;
`ifdef ALU_SEQ_NUM_INST_EN
    assign num_inst    = num_inst_q;
`endif

endmodule
